data_mem_resp: RTL and testbench

- Responder side of the datapath's data-memory interface.
- Accepts load/store requests from the core's MEM stage over a valid/ready handshake.
- Performs RV32I byte/halfword/word accesses with sign/zero extension against an internal word-organised RAM.
- Returns one response per request after a fixed, parameterised latency, so the core can be moved off single-cycle memory.

---
 rtl/data_mem_resp.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_resp.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one load/store at a time over valid/ready,
// performs the RV32I byte/halfword/word access against an internal word RAM
// and returns the result LATENCY cycles after the accept cycle.
module data_mem_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] Addr,
  input  logic        WrEn,
  input  logic [2:0]  MemOp,
  input  logic [31:0] DataIn,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] Memout,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [2:0]            mem_op_q, mem_op_d;
  logic [31:0]           data_in_q, data_in_d;
  logic [31:0]           memout_q, memout_d;
  logic                  err_q, err_d;

  logic [31:0]           mem_q [2**ADDR_WIDTH];

  logic                  commit;
  logic                  mem_we;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic                  acc_we;
  logic [2:0]            acc_op;
  logic [31:0]           acc_data;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;

  // Address bits above the RAM depth alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:ADDR_WIDTH+2];

  assign ReqReady  = (state_q == IDLE);
  assign RespValid = (state_q == RESP);
  assign Memout    = memout_q;
  assign Err       = err_q;

  // Access operands: with LATENCY=1 the commit happens on the accept edge, so
  // the live request inputs are used; otherwise the latched copy is used.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr = Addr[ADDR_WIDTH+1:0];
      acc_we   = WrEn;
      acc_op   = MemOp;
      acc_data = DataIn;
    end else begin
      acc_addr = addr_q;
      acc_we   = wr_en_q;
      acc_op   = mem_op_q;
      acc_data = data_in_q;
    end
  end

  // Decode size/alignment errors, extract and extend load data, build store lanes.
  always_comb begin
    word_idx = acc_addr[ADDR_WIDTH+1:2];
    lane     = acc_addr[1:0];
    rd_word  = mem_q[word_idx];
    ld_byte  = rd_word[{lane, 3'b000} +: 8];
    ld_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (acc_op)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = lane[0];
      3'b010:  acc_err = (lane != 2'b00);
      3'b100:  acc_err = acc_we;
      3'b101:  acc_err = acc_we | lane[0];
      default: acc_err = 1'b1;
    endcase

    case (acc_op)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = '0;
    endcase

    case (acc_op)
      3'b000: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{acc_data[7:0]}};
      end
      3'b001: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_data[15:0]}};
      end
      3'b010: begin
        wr_be   = 4'b1111;
        wr_data = acc_data;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = '0;
      end
    endcase
  end

  // Next-state and response logic for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_en_d   = wr_en_q;
    mem_op_d  = mem_op_q;
    data_in_d = data_in_q;
    memout_d  = memout_q;
    err_d     = err_q;
    commit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          addr_d    = Addr[ADDR_WIDTH+1:0];
          wr_en_d   = WrEn;
          mem_op_d  = MemOp;
          data_in_d = DataIn;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (RespReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      err_d    = acc_err;
      memout_d = (acc_err || acc_we) ? '0 : ld_data;
    end

    mem_we = commit & acc_we & ~acc_err;
  end

  // Control and response registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      mem_op_q  <= '0;
      data_in_q <= '0;
      memout_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      mem_op_q  <= mem_op_d;
      data_in_q <= data_in_d;
      memout_q  <= memout_d;
      err_q     <= err_d;
    end
  end

  // RAM byte-lane write; a reset on the commit edge drops the store.
  always_ff @(posedge Clk) begin
    if (!Rst && mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (LATENCY 2, 1, 5) checked every
// cycle against a byte-addressed transaction model, plus directed literals.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        wr_en     [3];
  logic [2:0]  mem_op    [3];
  logic [31:0] addr      [3];
  logic [31:0] data_in   [3];
  logic        resp_valid[3];
  logic        resp_ready[3];
  logic [31:0] memout    [3];
  logic        err_o     [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_resp #(
      .ADDR_WIDTH(10),
      .LATENCY   (g == 0 ? 2 : (g == 1 ? 1 : 5))
    ) u_dut (
      .Clk      (clk),
      .Rst      (rst),
      .ReqValid (req_valid[g]),
      .ReqReady (req_ready[g]),
      .Addr     (addr[g]),
      .WrEn     (wr_en[g]),
      .MemOp    (mem_op[g]),
      .DataIn   (data_in[g]),
      .RespValid(resp_valid[g]),
      .RespReady(resp_ready[g]),
      .Memout   (memout[g]),
      .Err      (err_o[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  bit          started = 0;
  logic        m_busy [3];
  logic        m_resp [3];
  int          m_cnt  [3];
  logic        c_we   [3];
  logic [2:0]  c_op   [3];
  logic [31:0] c_addr [3];
  logic [31:0] c_data [3];
  logic [31:0] m_data [3];
  logic        m_err  [3];
  logic [7:0]  mb     [3][4096];

  task automatic do_access(input int k);
    logic [11:0] a;
    logic [2:0]  op;
    logic [31:0] v;
    logic        bad;
    int          n;
    a   = c_addr[k][11:0];
    op  = c_op[k];
    bad = (op == 3'b011) || (op[2:1] == 2'b11) ||
          (op[1:0] == 2'b01 && a[0]) ||
          (op == 3'b010 && a[1:0] != 2'b00) ||
          (c_we[k] && op[2]);
    n   = (op[1:0] == 2'b00) ? 1 : ((op[1:0] == 2'b01) ? 2 : 4);
    m_err[k]  = bad;
    m_data[k] = '0;
    if (!bad) begin
      if (c_we[k]) begin
        for (int i = 0; i < n; i++) mb[k][int'(a) + i] = c_data[k][8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[k][int'(a) + i]) << (8*i));
        if (!op[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        m_data[k] = v;
      end
    end
    m_resp[k] = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) started = 1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_resp[k] = 1'b0;
      end else if (m_resp[k]) begin
        if (resp_ready[k]) begin
          m_resp[k] = 1'b0;
          m_busy[k] = 1'b0;
        end
      end else if (m_busy[k]) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) do_access(k);
      end else if (req_valid[k]) begin
        m_busy[k] = 1'b1;
        c_we[k]   = wr_en[k];
        c_op[k]   = mem_op[k];
        c_addr[k] = addr[k];
        c_data[k] = data_in[k];
        m_cnt[k]  = lat_of(k) - 1;
        if (m_cnt[k] == 0) do_access(k);
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (started && rst === 1'b0) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("req_ready[%0d]", k), 32'(req_ready[k]), 32'(!m_busy[k]));
        check($sformatf("resp_valid[%0d]", k), 32'(resp_valid[k]), 32'(m_resp[k]));
        if (m_resp[k]) begin
          check($sformatf("memout[%0d]", k), memout[k], m_data[k]);
          check($sformatf("err[%0d]", k), 32'(err_o[k]), 32'(m_err[k]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_accept(input int k);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!m_busy[k] && n < 50);
    if (!m_busy[k]) check("accept_timeout", 32'(m_busy[k]), 32'd1);
    req_valid[k] = 1'b0;
    addr[k]      = $urandom;
    data_in[k]   = $urandom;
  endtask

  task automatic xact(input int k, input logic we, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic re, output int lat);
    addr[k]      = a;
    wr_en[k]     = we;
    mem_op[k]    = op;
    data_in[k]   = d;
    req_valid[k] = 1'b1;
    wait_accept(k);
    lat = 1;
    while (resp_valid[k] !== 1'b1 && lat < 50) begin
      @(posedge clk); #2;
      lat++;
    end
    rd = memout[k];
    re = err_o[k];
    if (resp_ready[k]) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic run(input string name, input int k, input logic we, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        re;
    int          lat;
    xact(k, we, op, a, d, rd, re, lat);
    check({name, ".data"}, rd, exp_data);
    check({name, ".err"}, 32'(re), 32'(exp_err));
    check({name, ".lat"}, 32'(lat), 32'(lat_of(k)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      resp_ready[k] = 1'b1;
      wr_en[k]      = 1'b0;
      mem_op[k]     = 3'b010;
      addr[k]       = '0;
      data_in[k]    = '0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset.req_ready", 32'(req_ready[k]), 32'd1);
      check("reset.resp_valid", 32'(resp_valid[k]), 32'd0);
      check("reset.memout", memout[k], 32'd0);
      check("reset.err", 32'(err_o[k]), 32'd0);
    end

    // word store/load, then on the other latencies too
    for (int k = 0; k < 3; k++) begin
      run("st_w_10", k, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      run("ld_w_10", k, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    end

    // byte lane store and sign/zero extension
    run("st_b_11", 0, 1'b1, 3'b000, 32'h11, 32'h0000_0080, 32'h0, 1'b0);
    run("ld_b_11", 0, 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
    run("ld_bu_11", 0, 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_0080, 1'b0);
    run("ld_w_10b", 0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_80EF, 1'b0);

    // halfword
    run("st_h_12", 0, 1'b1, 3'b001, 32'h12, 32'h0000_8001, 32'h0, 1'b0);
    run("ld_h_12", 0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0);
    run("ld_hu_12", 0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8001, 1'b0);
    run("ld_h_13", 0, 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1);
    run("ld_w_10c", 0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h8001_80EF, 1'b0);

    // errors and aliasing
    run("st_w_14", 0, 1'b1, 3'b010, 32'h14, 32'hCAFE_F00D, 32'h0, 1'b0);
    run("st_w_16", 0, 1'b1, 3'b010, 32'h16, 32'h1234_5678, 32'h0, 1'b1);
    run("ld_w_14", 0, 1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0);
    run("ld_w_1010", 0, 1'b0, 3'b010, 32'h1010, 32'h0, 32'h8001_80EF, 1'b0);
    run("ld_op3", 0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    run("ld_op7", 0, 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1);
    run("st_bu", 0, 1'b1, 3'b100, 32'h14, 32'h0000_0011, 32'h0, 1'b1);
    run("st_h_15", 0, 1'b1, 3'b001, 32'h15, 32'h0000_2222, 32'h0, 1'b1);
    run("ld_w_14b", 0, 1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0);
    run("ld_b_17", 0, 1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFF_FFCA, 1'b0);

    // response back-pressure with a stray request pulse
    resp_ready[0] = 1'b0;
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, re, lat);
    check("hold.lat", 32'(lat), 32'd2);
    check("hold.data0", rd, 32'h8001_80EF);
    for (int c = 0; c < 5; c++) begin
      req_valid[0] = (c < 2);
      addr[0]      = 32'h14;
      wr_en[0]     = 1'b1;
      mem_op[0]    = 3'b010;
      data_in[0]   = 32'h5555_5555;
      @(posedge clk); #2;
      check("hold.data", memout[0], rd);
      check("hold.err", 32'(err_o[0]), 32'd0);
      check("hold.valid", 32'(resp_valid[0]), 32'd1);
      check("hold.ready", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk); #2;
    check("hold.release_valid", 32'(resp_valid[0]), 32'd0);
    check("hold.release_ready", 32'(req_ready[0]), 32'd1);
    run("hold.no_store", 0, 1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0);

    // reset one cycle after accepting a store
    for (int k = 0; k < 3; k++) begin
      run("rst.pre_store", k, 1'b1, 3'b010, 32'h20, 32'h1111_1111, 32'h0, 1'b0);
      addr[k]      = 32'h20;
      wr_en[k]     = 1'b1;
      mem_op[k]    = 3'b010;
      data_in[k]   = 32'h2222_2222;
      req_valid[k] = 1'b1;
      wait_accept(k);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        check("rst.no_resp", 32'(resp_valid[k]), 32'd0);
        check("rst.ready", 32'(req_ready[k]), 32'd1);
        @(posedge clk); #2;
      end
      run("rst.load", k, 1'b0, 3'b010, 32'h20, 32'h0,
          (k == 1) ? 32'h2222_2222 : 32'h1111_1111, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
